// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg
//   Shared defaults and state encoding for the product accumulator (MAC stage
//   behind the 4x4 array multiplier).
//   Contents: PROD_W_DEF / ACC_W_DEF / LEN_W_DEF widths, state_t FSM encoding.
package product_accumulator_pkg;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int LEN_W_DEF  = 4;

    // 2'd3 is unused and is steered back to IDLE by the FSM.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/product_accumulator_sat.sv
// sat_adder
//   Combinational saturating add of an ACC_W accumulator and a PROD_W product.
//   Ports:
//     a    in  ACC_W   running accumulator
//     b    in  PROD_W  product, zero-extended
//     sum  out ACC_W   a+b, clamped to all ones on carry-out
//     sat  out 1       carry-out occurred (sum was clamped)
module sat_adder #(
    parameter int ACC_W  = 16,
    parameter int PROD_W = 8
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              sat
);

    // One extra bit is enough: a <= 2**ACC_W-1 and b < 2**PROD_W <= 2**ACC_W.
    logic [ACC_W:0] full;

    assign full = {1'b0, a} + (ACC_W+1)'(b);
    assign sat  = full[ACC_W];
    assign sum  = sat ? '1 : full[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums a burst of len products from the multiplier into a saturating
//   accumulator and holds the total on a valid/ready result port.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     ena                 1 = run, 0 = freeze (prod_ready forced low)
//     start, len          begin a burst of len products (sampled in IDLE)
//     prod, prod_valid,
//     prod_ready          product input handshake
//     acc_out, acc_valid,
//     acc_ready           result handshake; acc_out holds after acceptance
//     overflow            burst saturated, valid with acc_valid
//     busy                FSM not in IDLE
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              overflow,
    output logic              busy
);

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [LEN_W-1:0]   count;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_m1;
    logic [ACC_W-1:0]   sum;
    logic               sat;

    sat_adder #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_adder (
        .a   (acc),
        .b   (prod),
        .sum (sum),
        .sat (sat)
    );

    // len_q is nonzero whenever we are in ACCUM, so len_m1 never wraps there.
    assign len_m1 = len_q - LEN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            len_q    <= '0;
            overflow <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                        count    <= '0;
                        len_q    <= len;
                        state    <= (len != '0) ? ACCUM : DONE;
                    end
                end
                ACCUM: begin
                    // prod_ready == ena here, so prod_valid alone is the handshake.
                    if (prod_valid) begin
                        acc      <= sum;
                        overflow <= overflow | sat;
                        count    <= count + LEN_W'(1);
                        if (count == len_m1)
                            state <= DONE;
                    end
                end
                DONE: begin
                    // start in this cycle is deliberately dropped; we only
                    // sample it from IDLE.
                    if (acc_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign prod_ready = (state == ACCUM) && ena;
    assign acc_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign acc_out    = acc;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
//   Directed and random stimulus against two instances (ACC_W=16 default and
//   ACC_W=10 to reach saturation) sharing one input bus. The reference keeps
//   the accepted products of the current burst in a queue and derives the
//   expected total/overflow by plain saturating summation.
module tb_product_accumulator;

    localparam int M_IDLE  = 0;
    localparam int M_ACCUM = 1;
    localparam int M_DONE  = 2;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic [3:0]  len;
    logic [7:0]  prod;
    logic        prod_valid;
    logic        acc_ready;

    logic        prod_ready16, acc_valid16, overflow16, busy16;
    logic [15:0] acc_out16;
    logic        prod_ready10, acc_valid10, overflow10, busy10;
    logic [9:0]  acc_out10;

    int checks   = 0;
    int failures = 0;

    // reference state
    int         m_phase;
    int         m_len;
    logic [7:0] m_q[$];

    product_accumulator u_dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .len        (len),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready16),
        .acc_out    (acc_out16),
        .acc_valid  (acc_valid16),
        .acc_ready  (acc_ready),
        .overflow   (overflow16),
        .busy       (busy16)
    );

    product_accumulator #(.ACC_W(10)) u_dut10 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .len        (len),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready10),
        .acc_out    (acc_out10),
        .acc_valid  (acc_valid10),
        .acc_ready  (acc_ready),
        .overflow   (overflow10),
        .busy       (busy10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Saturating sum of the accepted products at accumulator width w.
    function automatic void model_sum(input int w, output logic [31:0] s, output logic o);
        logic [31:0] mx;
        mx = (32'd1 << w) - 32'd1;
        s  = 0;
        o  = 1'b0;
        foreach (m_q[i]) begin
            s = s + 32'(m_q[i]);
            if (s > mx) begin
                s = mx;
                o = 1'b1;
            end
        end
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE;
        m_len   = 0;
        m_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] s16, s10;
        logic        o16, o10;
        logic        exp_rdy;
        model_sum(16, s16, o16);
        model_sum(10, s10, o10);
        exp_rdy = (m_phase == M_ACCUM) && ena;
        chk({tag, ".prod_ready16"}, prod_ready16, exp_rdy);
        chk({tag, ".prod_ready10"}, prod_ready10, exp_rdy);
        chk({tag, ".acc_valid16"},  acc_valid16,  m_phase == M_DONE);
        chk({tag, ".acc_valid10"},  acc_valid10,  m_phase == M_DONE);
        chk({tag, ".busy16"},       busy16,       m_phase != M_IDLE);
        chk({tag, ".busy10"},       busy10,       m_phase != M_IDLE);
        chk({tag, ".acc_out16"},    acc_out16,    s16);
        chk({tag, ".acc_out10"},    acc_out10,    s10);
        chk({tag, ".overflow16"},   overflow16,   o16);
        chk({tag, ".overflow10"},   overflow10,   o10);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".prod_ready16"}, prod_ready16, 0);
        chk({tag, ".acc_valid16"},  acc_valid16,  0);
        chk({tag, ".overflow16"},   overflow16,   0);
        chk({tag, ".busy16"},       busy16,       0);
        chk({tag, ".acc_out16"},    acc_out16,    0);
        chk({tag, ".prod_ready10"}, prod_ready10, 0);
        chk({tag, ".acc_valid10"},  acc_valid10,  0);
        chk({tag, ".overflow10"},   overflow10,   0);
        chk({tag, ".busy10"},       busy10,       0);
        chk({tag, ".acc_out10"},    acc_out10,    0);
    endtask

    // One clock cycle: apply inputs, check against the reference, then
    // advance the reference by the rules for the coming rising edge.
    // Entered and left at posedge+1.
    task automatic tick(input string tag, input logic st, input logic [3:0] ln,
                        input logic pv, input logic [7:0] pd,
                        input logic en, input logic ar);
        start      = st;
        len        = ln;
        prod_valid = pv;
        prod       = pd;
        ena        = en;
        acc_ready  = ar;
        #1;
        check_outputs(tag);
        if (en) begin
            case (m_phase)
                M_IDLE: if (st) begin
                    m_q.delete();
                    m_len   = int'(ln);
                    m_phase = (ln != 0) ? M_ACCUM : M_DONE;
                end
                M_ACCUM: if (pv) begin
                    m_q.push_back(pd);
                    if (m_q.size() == m_len) m_phase = M_DONE;
                end
                M_DONE: if (ar) m_phase = M_IDLE;
                default: m_phase = M_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b0;
        start      = 1'b0;
        len        = '0;
        prod       = '0;
        prod_valid = 1'b0;
        acc_ready  = 1'b0;
        model_reset();

        // reset values, before any clock edge
        #2;
        check_all_zero("reset_initial");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick("idle", 0, 0, 0, 0, 1, 0);

        // burst len=3, 225 x3 back-to-back
        tick("b3_start", 1, 3, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick("b3_prod", 0, 0, 1, 8'd225, 1, 0);
        chk("b3_latency_valid", acc_valid16, 1);
        chk("b3_sum16", acc_out16, 16'h02A3);
        chk("b3_ovf16", overflow16, 0);
        tick("b3_accept", 0, 0, 0, 0, 1, 1);
        tick("b3_after", 0, 0, 0, 0, 1, 0);
        chk("b3_hold_after_accept", acc_out16, 16'h02A3);

        // saturation at ACC_W=10, len=5, 225 x5
        tick("sat_start", 1, 5, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) tick("sat_prod", 0, 0, 1, 8'd225, 1, 0);
        chk("sat_sum10", acc_out10, 10'h3FF);
        chk("sat_ovf10", overflow10, 1);
        chk("sat_sum16", acc_out16, 16'd1125);
        tick("sat_accept", 0, 0, 0, 0, 1, 1);
        tick("sat2_start", 1, 1, 0, 0, 1, 0);
        tick("sat2_prod", 0, 0, 1, 8'd4, 1, 0);
        chk("sat2_sum10", acc_out10, 10'h004);
        chk("sat2_ovf10", overflow10, 0);
        tick("sat2_accept", 0, 0, 0, 0, 1, 1);

        // backpressure and ena freeze, len=4, prods 1..4
        tick("bp_start", 1, 4, 0, 0, 1, 0);
        tick("bp_p1", 0, 0, 1, 8'd1, 1, 0);
        tick("bp_gap", 0, 0, 0, 8'd77, 1, 0);
        tick("bp_p2", 0, 0, 1, 8'd2, 1, 0);
        for (int i = 0; i < 3; i++) tick("bp_ena0", 0, 0, 1, 8'd99, 0, 0);
        tick("bp_p3", 0, 0, 1, 8'd3, 1, 0);
        tick("bp_gap2", 0, 0, 0, 8'd55, 1, 0);
        tick("bp_p4", 0, 0, 1, 8'd4, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick("bp_hold", 0, 0, 0, 0, 1, 0);
            chk("bp_sum_stable", acc_out16, 16'd10);
        end
        tick("bp_ena0_ready", 0, 0, 0, 0, 0, 1);
        chk("bp_no_accept_ena0", acc_valid16, 1);
        tick("bp_accept", 0, 0, 0, 0, 1, 1);

        // len=0, and start ignored in ACCUM/DONE
        tick("l0_start", 1, 0, 0, 0, 1, 0);
        chk("l0_valid", acc_valid16, 1);
        chk("l0_sum", acc_out16, 0);
        tick("l0_start_in_done", 1, 7, 0, 0, 1, 0);
        tick("l0_accept_with_start", 1, 7, 0, 0, 1, 1);
        chk("l0_start_dropped", busy16, 0);
        tick("ig_start", 1, 2, 0, 0, 1, 0);
        tick("ig_start_in_accum", 1, 9, 1, 8'd20, 1, 0);
        tick("ig_p2", 0, 0, 1, 8'd30, 1, 0);
        chk("ig_sum", acc_out16, 16'd50);
        tick("ig_accept", 0, 0, 0, 0, 1, 1);

        // reset mid-burst, then a fresh burst
        tick("rm_start", 1, 4, 0, 0, 1, 0);
        tick("rm_p1", 0, 0, 1, 8'd5, 1, 0);
        tick("rm_p2", 0, 0, 1, 8'd6, 1, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick("rm2_start", 1, 2, 0, 0, 1, 0);
        tick("rm2_p1", 0, 0, 1, 8'd7, 1, 0);
        tick("rm2_p2", 0, 0, 1, 8'd9, 1, 0);
        chk("rm2_sum", acc_out16, 16'd16);
        tick("rm2_accept", 0, 0, 0, 0, 1, 1);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            tick("rnd",
                 ($urandom % 4) == 0,
                 4'($urandom_range(0, 15)),
                 ($urandom % 4) != 0,
                 8'($urandom_range(0, 255)),
                 ($urandom % 8) != 0,
                 ($urandom % 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
